// File: rtl/demux_16b_1to2_reg_if.sv
// demux_16b_1to2_reg_if: handshake bundle for the registered 1:2 demux
// Signals: in_data/in_sel/in_valid/in_ready input side, outN_data/outN_valid/outN_ready per output.
// Modports: master = upstream source plus both destinations, slave = the demux itself.
interface demux_16b_1to2_reg_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_ready;
    modport master (
        output in_data, in_sel, in_valid, out1_ready, out2_ready,
        input  in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
    modport slave (
        input  in_data, in_sel, in_valid, out1_ready, out2_ready,
        output in_ready, out1_data, out1_valid, out2_data, out2_valid
    );
endinterface

// File: rtl/demux_16b_1to2_reg.sv
// demux_16b_1to2_reg: registered 1:2 demux with valid/ready handshake, flush and one holding slot per output
// Ports: clk, rst (async active-high), flush (sync clear of both slots), bus (slave modport),
//        cnt1/cnt2 per-output saturating transfer counters only when DEMUX_16B_CNT_EN is defined.
module demux_16b_1to2_reg #(
    parameter int WIDTH = 16
`ifdef DEMUX_16B_CNT_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
`ifdef DEMUX_16B_CNT_EN
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
`endif
    demux_16b_1to2_reg_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_e;
    slot_e            st1_q, st1_d, st2_q, st2_d;
    logic [WIDTH-1:0] data1_q, data1_d, data2_q, data2_d;
    logic             sel2, drain1, drain2, ready, acc1, acc2;
    // Anything but a clean 1 steers to output 1, like the mux default arm.
    assign sel2   = (bus.in_sel === 1'b1);
    assign drain1 = (st1_q == FULL) && bus.out1_ready;
    assign drain2 = (st2_q == FULL) && bus.out2_ready;
    // A slot can take a word when empty or when it is being emptied this same cycle.
    assign ready  = !rst && !flush && (sel2 ? (st2_q == EMPTY || drain2) : (st1_q == EMPTY || drain1));
    assign acc1   = bus.in_valid && ready && !sel2;
    assign acc2   = bus.in_valid && ready && sel2;
    always_comb begin
        st1_d   = flush ? EMPTY : acc1 ? FULL : drain1 ? EMPTY : st1_q;
        st2_d   = flush ? EMPTY : acc2 ? FULL : drain2 ? EMPTY : st2_q;
        data1_d = acc1 ? bus.in_data : data1_q;
        data2_d = acc2 ? bus.in_data : data2_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_q   <= EMPTY;
            st2_q   <= EMPTY;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            st1_q   <= st1_d;
            st2_q   <= st2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end
    assign bus.in_ready   = ready;
    assign bus.out1_valid = (st1_q == FULL);
    assign bus.out2_valid = (st2_q == FULL);
    assign bus.out1_data  = data1_q;
    assign bus.out2_data  = data2_q;
`ifdef DEMUX_16B_CNT_EN
    logic [CNT_W-1:0] cnt1_q, cnt2_q;
    // Counters saturate at all-ones; a flush cycle is not a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= (drain1 && !flush && cnt1_q != '1) ? cnt1_q + 1'b1 : cnt1_q;
            cnt2_q <= (drain2 && !flush && cnt2_q != '1) ? cnt2_q + 1'b1 : cnt2_q;
        end
    end
    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`endif
endmodule

// File: tb/tb_demux_16b_1to2_reg.sv
// tb_demux_16b_1to2_reg: directed, table-driven bench for demux_16b_1to2_reg
module tb_demux_16b_1to2_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;
    demux_16b_1to2_reg_if #(.WIDTH(16)) bus ();
`ifdef DEMUX_16B_CNT_EN
    logic [7:0] cnt1, cnt2;
    demux_16b_1to2_reg #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cnt1(cnt1), .cnt2(cnt2), .bus(bus)
    );
`else
    demux_16b_1to2_reg #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus)
    );
`endif
    always #5 clk = ~clk;
    typedef struct {
        logic        sel;
        logic        valid;
        logic [15:0] data;
        logic        r1;
        logic        r2;
        logic        fl;
        logic        rdy;
        logic        v1;
        logic [15:0] d1;
        logic        v2;
        logic [15:0] d2;
    } vec_t;
    vec_t vecs[10];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic drive(input logic sel, input logic valid, input logic [15:0] data,
                         input logic r1, input logic r2, input logic fl);
        @(negedge clk);
        bus.in_sel = sel;
        bus.in_valid = valid;
        bus.in_data = data;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
        flush = fl;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.in_sel = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        //          sel valid data     r1 r2 fl rdy v1 d1        v2 d2
        vecs[0] = '{0, 1, 16'hA5A5, 0, 0, 0, 1, 1, 16'hA5A5, 0, 16'h0000};
        vecs[1] = '{0, 0, 16'h0000, 1, 0, 0, 1, 0, 16'hA5A5, 0, 16'h0000};
        vecs[2] = '{0, 1, 16'h1234, 0, 0, 0, 1, 1, 16'h1234, 0, 16'h0000};
        vecs[3] = '{0, 1, 16'hDEAD, 0, 0, 0, 0, 1, 16'h1234, 0, 16'h0000};
        vecs[4] = '{1, 1, 16'hBEEF, 0, 0, 0, 1, 1, 16'h1234, 1, 16'hBEEF};
        vecs[5] = '{1, 1, 16'hCAFE, 0, 0, 0, 0, 1, 16'h1234, 1, 16'hBEEF};
        vecs[6] = '{0, 1, 16'h1111, 1, 1, 0, 1, 1, 16'h1111, 0, 16'hBEEF};
        vecs[7] = '{1, 1, 16'h2222, 0, 0, 0, 1, 1, 16'h1111, 1, 16'h2222};
        vecs[8] = '{0, 1, 16'h3333, 1, 1, 1, 0, 0, 16'h1111, 0, 16'h2222};
        vecs[9] = '{1, 0, 16'h4444, 0, 0, 0, 1, 0, 16'h1111, 0, 16'h2222};
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 0);
        chk("reset out1_valid", 32'(bus.out1_valid), 0);
        chk("reset out2_valid", 32'(bus.out2_valid), 0);
        chk("reset out1_data", 32'(bus.out1_data), 0);
        chk("reset out2_data", 32'(bus.out2_data), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].r1, vecs[i].r2, vecs[i].fl);
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
            tick();
            chk($sformatf("vec%0d out1_valid", i), 32'(bus.out1_valid), 32'(vecs[i].v1));
            chk($sformatf("vec%0d out1_data", i), 32'(bus.out1_data), 32'(vecs[i].d1));
            chk($sformatf("vec%0d out2_valid", i), 32'(bus.out2_valid), 32'(vecs[i].v2));
            chk($sformatf("vec%0d out2_data", i), 32'(bus.out2_data), 32'(vecs[i].d2));
        end
        // Async reset with both slots full.
        drive(0, 1, 16'hAAAA, 0, 0, 0);
        tick();
        drive(1, 1, 16'hBBBB, 0, 0, 0);
        tick();
        chk("prerst out1_valid", 32'(bus.out1_valid), 1);
        chk("prerst out2_valid", 32'(bus.out2_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("asyncrst out1_valid", 32'(bus.out1_valid), 0);
        chk("asyncrst out2_valid", 32'(bus.out2_valid), 0);
        chk("asyncrst in_ready", 32'(bus.in_ready), 0);
`ifdef DEMUX_16B_CNT_EN
        chk("asyncrst cnt1", 32'(cnt1), 0);
        chk("asyncrst cnt2", 32'(cnt2), 0);
`endif
        drive(0, 0, 16'h0000, 0, 0, 0);
        rst = 1'b0;
        // Back-to-back stream on output 2.
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 16'(k), 0, 1, 0);
            chk($sformatf("stream%0d in_ready", k), 32'(bus.in_ready), 1);
            tick();
            chk($sformatf("stream%0d out2_data", k), 32'(bus.out2_data), k);
            chk($sformatf("stream%0d out2_valid", k), 32'(bus.out2_valid), 1);
        end
        drive(1, 0, 16'h0000, 0, 1, 0);
        tick();
        chk("stream end out2_valid", 32'(bus.out2_valid), 0);
        chk("stream out1_valid", 32'(bus.out1_valid), 0);
`ifdef DEMUX_16B_CNT_EN
        chk("stream cnt2", 32'(cnt2), 4);
        chk("stream cnt1", 32'(cnt1), 0);
`endif
        // 300 transfers on output 1 from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 16'(i), 1, 0, 0);
            if (bus.in_ready !== 1'b1) chk($sformatf("sat%0d in_ready", i), 32'(bus.in_ready), 1);
            tick();
        end
        chk("sat last out1_data", 32'(bus.out1_data), 299);
        chk("sat last out1_valid", 32'(bus.out1_valid), 1);
        drive(0, 0, 16'h0000, 1, 0, 0);
        tick();
        chk("sat drained out1_valid", 32'(bus.out1_valid), 0);
        chk("sat held out1_data", 32'(bus.out1_data), 299);
`ifdef DEMUX_16B_CNT_EN
        chk("sat cnt1", 32'(cnt1), 255);
        chk("sat cnt2", 32'(cnt2), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
